// File: rtl/shape_sequencer.sv
// Shape select sequencer: manual step / timed auto-cycle over the shape set,
// with a blanking gap on every shape change.
module shape_sequencer #(
  parameter int NUM_SHAPES   = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 26
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       Next_deb,
  input  logic       Pre_deb,
  input  logic       Auto_deb,
  output logic [3:0] Enable_SW,
  output logic [1:0] Shape_Idx,
  output logic       Auto_On,
  output logic       Blanking,
  output logic       Change_Stb
);

  localparam logic [1:0] LAST = 2'(NUM_SHAPES - 1);
  localparam logic [CNT_W-1:0] DWELL_TC =
    CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_TC =
    CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_MANUAL,
    S_AUTO,
    S_BLANK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_d;
  logic             auto_d;
  logic             stb_d;

  logic [2:0] deb, prev_q, edg_q;
  logic       ev_next, ev_pre, ev_auto;

  assign deb     = {Auto_deb, Pre_deb, Next_deb};
  assign ev_next = edg_q[0] & ~edg_q[1];
  assign ev_pre  = edg_q[1] & ~edg_q[0];
  assign ev_auto = edg_q[2];

  function automatic logic [1:0] idx_inc(
    input logic [1:0] i
  );
    return (i == LAST) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [1:0] idx_dec(
    input logic [1:0] i
  );
    return (i == 2'd0) ? LAST : i - 2'd1;
  endfunction

  // Edges are registered, so they act one cycle after sampling.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      edg_q  <= '0;
    end else begin
      prev_q <= deb;
      edg_q  <= deb & ~prev_q;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_MANUAL;
      cnt_q      <= '0;
      Shape_Idx  <= 2'd0;
      Auto_On    <= 1'b0;
      Change_Stb <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      Shape_Idx  <= idx_d;
      Auto_On    <= auto_d;
      Change_Stb <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = Shape_Idx;
    auto_d  = Auto_On;
    stb_d   = 1'b0;
    unique case (state_q)
      S_MANUAL, S_AUTO: begin
        if (ev_auto) begin
          auto_d  = ~Auto_On;
          state_d = Auto_On ? S_MANUAL : S_AUTO;
          cnt_d   = '0;
        end else if (ev_next) begin
          idx_d   = idx_inc(Shape_Idx);
          state_d = S_BLANK;
          cnt_d   = '0;
        end else if (ev_pre) begin
          idx_d   = idx_dec(Shape_Idx);
          state_d = S_BLANK;
          cnt_d   = '0;
        end else if (state_q == S_AUTO) begin
          if (cnt_q == DWELL_TC) begin
            idx_d   = idx_inc(Shape_Idx);
            state_d = S_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_BLANK: begin
        if (ev_auto) auto_d = ~Auto_On;
        if (cnt_q == BLANK_TC) begin
          cnt_d   = '0;
          stb_d   = 1'b1;
          state_d = auto_d ? S_AUTO : S_MANUAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_MANUAL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    Blanking  = (state_q == S_BLANK);
    Enable_SW = 4'b0000;
    if (state_q != S_BLANK) Enable_SW = 4'b0001 << Shape_Idx;
  end

endmodule
